// File: rtl/dma_tx_arbiter.sv
// dma_tx_arbiter
//   Arbitrates between a read requester and a write requester and serialises
//   the winning request onto a byte-wide link.
//   Each packet is sent in this order:
//     - header byte {length[5:0], type[1:0]};
//     - address high byte, then address low byte;
//     - for writes only, 36 tile bytes, MSB first.
//   Reads that have been sent but whose completion has not yet returned are
//   counted in `outstanding`. A new read is only issued while that count is
//   below MAX_OUTSTANDING.
//
//   Build option: define DMA_TX_WRITE_EN to compile in the write path (write
//   packets, TILE state, tile latch). Without it the block is read-only and
//   wr_req_ready is tied low.
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-high
//   rd_req_valid  read request pending
//   rd_req_addr   read tile address (16 bits)
//   rd_req_ready  read request accepted this cycle (combinational, IDLE only)
//   wr_req_valid  write request pending
//   wr_req_addr   write tile address (16 bits)
//   wr_req_tile   4x4x18-bit write tile payload (288 bits)
//   wr_req_ready  write request accepted this cycle (combinational, IDLE only)
//   rd_done_stb   one read completion has returned
//   tx_ready      link accepts a byte this cycle
//   tx_stb        tx_data valid
//   tx_data       outgoing byte, held while tx_stb=1 and tx_ready=0
//   outstanding   reads in flight
//   busy          state is not IDLE
module dma_tx_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_req_valid,
  input  logic [15:0]   rd_req_addr,
  output logic          rd_req_ready,
  input  logic          wr_req_valid,
  input  logic [15:0]   wr_req_addr,
  input  logic [287:0]  wr_req_tile,
  output logic          wr_req_ready,
  input  logic          rd_done_stb,
  input  logic          tx_ready,
  output logic          tx_stb,
  output logic [7:0]    tx_data,
  output logic [OW-1:0] outstanding,
  output logic          busy
);

  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);
  localparam logic [7:0]    RD_HDR  = {6'd2, 2'd1};
  localparam logic [7:0]    WR_HDR  = {6'd38, 2'd2};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    ADDR_HI = 3'd2,
`ifdef DMA_TX_WRITE_EN
    ADDR_LO = 3'd3,
    TILE    = 3'd4
`else
    ADDR_LO = 3'd3
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   addr_q;
  logic          last_wr_q;   // 1 = write granted last; reset so read wins first tie
  logic          rd_elig, wr_elig;
  logic          grant_rd, grant_wr;
  logic          xfer;
  logic          out_inc, out_dec;
  logic          pkt_wr;

`ifdef DMA_TX_WRITE_EN
  logic          pkt_wr_q;
  logic [287:0]  tile_q;      // shifts left one byte per TILE transfer
  logic [5:0]    cnt_q;
  assign pkt_wr  = pkt_wr_q;
  assign wr_elig = wr_req_valid;
`else
  logic          unused_wr;
  assign unused_wr = ^{wr_req_valid, wr_req_addr, wr_req_tile};
  assign pkt_wr  = 1'b0;
  assign wr_elig = 1'b0;
`endif

  assign rd_elig = rd_req_valid && (outstanding < MAX_CNT);

  // Round-robin: on a tie the side that did not win last time is granted.
  // Reset gates the grants so no request is accepted during reset.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (rd_elig && wr_elig) begin
        grant_rd = last_wr_q;
        grant_wr = !last_wr_q;
      end else begin
        grant_rd = rd_elig;
        grant_wr = wr_elig;
      end
    end
  end

  assign xfer = tx_stb && tx_ready;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_rd || grant_wr) state_d = HEADER;
      HEADER:  if (tx_ready) state_d = ADDR_HI;
      ADDR_HI: if (tx_ready) state_d = ADDR_LO;
`ifdef DMA_TX_WRITE_EN
      ADDR_LO: if (tx_ready) state_d = pkt_wr ? TILE : IDLE;
      TILE:    if (tx_ready && cnt_q == 6'd35) state_d = IDLE;
`else
      ADDR_LO: if (tx_ready) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    rd_req_ready = grant_rd;
    wr_req_ready = grant_wr;
    tx_stb       = (state_q != IDLE);
    busy         = (state_q != IDLE);
    tx_data      = 8'h00;
    case (state_q)
      HEADER:  tx_data = pkt_wr ? WR_HDR : RD_HDR;
      ADDR_HI: tx_data = addr_q[15:8];
      ADDR_LO: tx_data = addr_q[7:0];
`ifdef DMA_TX_WRITE_EN
      TILE:    tx_data = tile_q[287:280];
`endif
      default: tx_data = 8'h00;
    endcase
  end

  // ---- control registers ----
  // A read counts as in flight once its last address byte leaves.
  assign out_inc = (state_q == ADDR_LO) && xfer && !pkt_wr;
  assign out_dec = rd_done_stb && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr_q   <= 1'b1;
      outstanding <= '0;
    end else begin
      if (grant_rd)      last_wr_q <= 1'b0;
      else if (grant_wr) last_wr_q <= 1'b1;

      if (out_inc && rd_done_stb) outstanding <= outstanding;
      else if (out_inc)           outstanding <= outstanding + 1'b1;
      else if (out_dec)           outstanding <= outstanding - 1'b1;
    end
  end

`ifdef DMA_TX_WRITE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 6'd0;
    end else if (grant_wr || grant_rd) begin
      cnt_q <= 6'd0;
    end else if (state_q == TILE && xfer) begin
      cnt_q <= cnt_q + 6'd1;
    end
  end
`endif

  // ---- data latches (no reset: only read while a packet is active) ----
  always_ff @(posedge clk) begin
    if (grant_rd)      addr_q <= rd_req_addr;
`ifdef DMA_TX_WRITE_EN
    else if (grant_wr) addr_q <= wr_req_addr;
`endif
  end

`ifdef DMA_TX_WRITE_EN
  always_ff @(posedge clk) begin
    if (grant_wr || grant_rd) pkt_wr_q <= grant_wr;
    if (grant_wr)
      tile_q <= wr_req_tile;
    else if (state_q == TILE && xfer)
      tile_q <= {tile_q[279:0], 8'h00};
  end
`endif

endmodule

// File: tb/tb_dma_tx_arbiter.sv
module tb_dma_tx_arbiter;
  localparam int MAXO = 4;
  localparam int OW   = $clog2(MAXO + 1);
`ifdef DMA_TX_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req_valid;
  logic [15:0]   rd_req_addr;
  logic          rd_req_ready;
  logic          wr_req_valid;
  logic [15:0]   wr_req_addr;
  logic [287:0]  wr_req_tile;
  logic          wr_req_ready;
  logic          rd_done_stb;
  logic          tx_ready;
  logic          tx_stb;
  logic [7:0]    tx_data;
  logic [OW-1:0] outstanding;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_tx_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_tile(wr_req_tile),
    .wr_req_ready(wr_req_ready), .rd_done_stb(rd_done_stb), .tx_ready(tx_ready),
    .tx_stb(tx_stb), .tx_data(tx_data), .outstanding(outstanding), .busy(busy)
  );

  // Reference model: the packet in progress is a queue of the bytes still to send.
  bit          m_send;
  byte unsigned m_q[$];
  bit          m_rd;
  int          m_idx;
  int          m_out;
  bit          m_last_wr;

  // Observations from the DUT, used for scenario-level checks.
  byte unsigned obs_bytes[$];
  bit           g_log[$];     // 0 = read grant, 1 = write grant

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_send = 0; m_q.delete(); m_rd = 0; m_idx = 0; m_out = 0; m_last_wr = 1;
  endtask

  task automatic clear_obs();
    obs_bytes.delete(); g_log.delete();
  endtask

  // Called shortly after a falling edge with inputs already driven: compare,
  // advance the model across the rising edge, return at the next falling edge.
  task automatic step();
    bit rd_el, wr_el, g_rd, g_wr, e_stb, inc;
    logic [7:0] e_data;
    #1;
    rd_el = rd_req_valid && (m_out < MAXO);
    wr_el = WR_EN && wr_req_valid;
    g_rd = 0; g_wr = 0;
    if (!m_send && !reset) begin
      if (rd_el && wr_el) begin
        if (m_last_wr) g_rd = 1; else g_wr = 1;
      end else if (rd_el) g_rd = 1;
      else if (wr_el) g_wr = 1;
    end
    e_stb  = m_send;
    e_data = m_send ? m_q[0] : 8'h00;
    chk("tx_stb", tx_stb, e_stb);
    chk("tx_data", tx_data, e_data);
    chk("busy", busy, e_stb);
    chk("rd_req_ready", rd_req_ready, g_rd);
    chk("wr_req_ready", wr_req_ready, g_wr);
    chk("outstanding", outstanding, m_out);
    if (rd_req_ready === 1'b1) g_log.push_back(1'b0);
    if (wr_req_ready === 1'b1) g_log.push_back(1'b1);
    if (tx_stb === 1'b1 && tx_ready) obs_bytes.push_back(tx_data);

    if (reset) begin
      model_reset();
    end else begin
      inc = m_send && tx_ready && m_rd && (m_idx == 2);
      if (inc && rd_done_stb) m_out = m_out;
      else if (inc) m_out++;
      else if (rd_done_stb && m_out > 0) m_out--;
      if (m_send && tx_ready) begin
        void'(m_q.pop_front());
        m_idx++;
        if (m_q.size() == 0) m_send = 0;
      end else if (g_rd) begin
        m_q = '{}; m_q.push_back({6'd2, 2'd1});
        m_q.push_back(rd_req_addr[15:8]); m_q.push_back(rd_req_addr[7:0]);
        m_rd = 1; m_idx = 0; m_send = 1; m_last_wr = 0;
      end else if (g_wr) begin
        m_q = '{}; m_q.push_back({6'd38, 2'd2});
        m_q.push_back(wr_req_addr[15:8]); m_q.push_back(wr_req_addr[7:0]);
        for (int i = 0; i < 36; i++) m_q.push_back(wr_req_tile[287 - 8*i -: 8]);
        m_rd = 0; m_idx = 0; m_send = 1; m_last_wr = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_tile(output logic [287:0] t);
    for (int i = 0; i < 9; i++) t[32*i +: 32] = $urandom;
  endtask

  task automatic do_reset();
    reset = 1; rd_req_valid = 0; wr_req_valid = 0; rd_done_stb = 0; tx_ready = 1;
    step();
    reset = 0;
  endtask

  initial begin
    logic [287:0] t;
    reset = 1; rd_req_valid = 1; rd_req_addr = 16'h1111; wr_req_valid = 1;
    wr_req_addr = 16'h2222; wr_req_tile = '0; rd_done_stb = 0; tx_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state, valids high: nothing may be accepted while in reset.
    step(); step();
    chk("reset_out", outstanding, 0);

    // Single read of 16'h1234.
    reset = 0; wr_req_valid = 0; clear_obs();
    rd_req_valid = 1; rd_req_addr = 16'h1234;
    step();
    rd_req_valid = 0;
    repeat (5) step();
    chk("rd_nbytes", obs_bytes.size(), 3);
    chk("rd_b0", obs_bytes[0], 8'h09);
    chk("rd_b1", obs_bytes[1], 8'h12);
    chk("rd_b2", obs_bytes[2], 8'h34);
    chk("rd_ngrants", g_log.size(), 1);
    chk("rd_out", outstanding, 1);

    // Write of 16'h00A5 (or, without the write path, an ignored write).
    clear_obs();
    rand_tile(t); t[287:280] = 8'hDE; t[7:0] = 8'hAD;
    wr_req_valid = 1; wr_req_addr = 16'h00A5; wr_req_tile = t;
    step();
    wr_req_valid = WR_EN ? 1'b0 : 1'b1;
    repeat (42) step();
    wr_req_valid = 0;
`ifdef DMA_TX_WRITE_EN
    chk("wr_nbytes", obs_bytes.size(), 39);
    chk("wr_b0", obs_bytes[0], 8'h9A);
    chk("wr_b1", obs_bytes[1], 8'h00);
    chk("wr_b2", obs_bytes[2], 8'hA5);
    chk("wr_b3", obs_bytes[3], 8'hDE);
    chk("wr_blast", obs_bytes[38], 8'hAD);
`else
    chk("nowr_nbytes", obs_bytes.size(), 0);
    chk("nowr_ngrants", g_log.size(), 0);
`endif
    chk("wr_out", outstanding, 1);

    // Both valid continuously, completions always returning.
    do_reset(); clear_obs();
    rd_req_valid = 1; wr_req_valid = 1; rd_req_addr = 16'h0F0F; rd_done_stb = 1;
    rand_tile(t); wr_req_tile = t;
    repeat (100) step();
    rd_req_valid = 0; wr_req_valid = 0; rd_done_stb = 0;
    repeat (45) step();
    chk("rr_g0", g_log[0], 1'b0);
    chk("rr_g1", g_log[1], WR_EN);
    chk("rr_g2", g_log[2], 1'b0);
    chk("rr_g3", g_log[3], WR_EN);

    // Fill outstanding to the limit, then a write must still get through.
    do_reset(); clear_obs();
    rd_req_valid = 1; rd_req_addr = 16'h4455;
    repeat (20) step();
    chk("full_out", outstanding, 4);
    chk("full_ngrants", g_log.size(), 4);
    wr_req_valid = 1; wr_req_addr = 16'h6677;
    repeat (3) step();
    wr_req_valid = 0;
    chk("stall_ngrants", g_log.size(), WR_EN ? 5 : 4);
    if (g_log.size() > 4) chk("stall_wr_grant", g_log[4], 1'b1);
    repeat (42) step();
    rd_done_stb = 1; step(); rd_done_stb = 0;
    repeat (6) step();
    rd_req_valid = 0;
    chk("refill_last_rd", g_log[g_log.size()-1], 1'b0);
    chk("refill_out", outstanding, 4);

    // tx_ready stalls during a read; completion coinciding with ADDR_LO.
    do_reset(); clear_obs();
    rd_req_valid = 1; rd_req_addr = 16'h0001; step(); rd_req_valid = 0;
    repeat (4) step();
    clear_obs();
    rd_req_valid = 1; rd_req_addr = 16'hABCD; step(); rd_req_valid = 0;
    tx_ready = 1; step();          // header
    tx_ready = 0; step(); step();  // addr hi held
    tx_ready = 1; step();          // addr hi
    rd_done_stb = 1; step();       // addr lo with completion
    rd_done_stb = 0; step();
    chk("stall_nbytes", obs_bytes.size(), 3);
    chk("stall_b1", obs_bytes[1], 8'hAB);
    chk("stall_b2", obs_bytes[2], 8'hCD);
    chk("stall_out", outstanding, 1);

    // Reset in the middle of a packet.
    do_reset(); clear_obs();
`ifdef DMA_TX_WRITE_EN
    wr_req_valid = 1; wr_req_addr = 16'h1357; rand_tile(t); wr_req_tile = t;
    step(); wr_req_valid = 0;
    repeat (13) step();
`else
    rd_req_valid = 1; rd_req_addr = 16'h1357; step(); rd_req_valid = 0;
    repeat (1) step();
`endif
    reset = 1; step(); reset = 0;
    chk("abort_stb", tx_stb, 1'b0);
    chk("abort_data", tx_data, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rdy", rd_req_ready, 1'b0);
    chk("abort_wrdy", wr_req_ready, 1'b0);
    chk("abort_out", outstanding, 0);
    repeat (5) step();
    chk("abort_out2", outstanding, 0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(299) == 0);
      rd_req_valid = ($urandom_range(3) != 0);
      rd_req_addr  = 16'($urandom);
      wr_req_valid = ($urandom_range(2) == 0);
      wr_req_addr  = 16'($urandom);
      rand_tile(t); wr_req_tile = t;
      rd_done_stb  = ($urandom_range(5) == 0);
      tx_ready     = ($urandom_range(3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
